// File: rtl/zorro_pkg.sv
// Shared constants and state encoding for the Zorro III slave target.
package zorro_pkg;

    // Function code for CPU space cycles; such cycles are never claimed.
    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

    // All four data strobes negated.
    localparam logic [3:0] DSN_IDLE = 4'hF;

    // State encoding of the bus-cycle FSM.
    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_IGNORE_ENC  = 3'd1;
    localparam logic [2:0] ST_MATCH_ENC   = 3'd2;
    localparam logic [2:0] ST_ACCESS_ENC  = 3'd3;
    localparam logic [2:0] ST_RESPOND_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_IGNORE  = ST_IGNORE_ENC,
        ST_MATCH   = ST_MATCH_ENC,
        ST_ACCESS  = ST_ACCESS_ENC,
        ST_RESPOND = ST_RESPOND_ENC
    } zorro_state_e;

endpackage

// File: rtl/zorro_sync2.sv
// Two-flop synchronizer for bus strobes that are asynchronous to CLK.
// The reset value is an input so each strobe can idle at its negated level.
module zorro_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic [WIDTH-1:0] RST_VAL,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop presents a settled value.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            meta <= RST_VAL;
            Q    <= RST_VAL;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/zorro_slave_target.sv
// Zorro III slave/target responder. Claims bus cycles addressed to this
// card, runs a level request / pulse ack handshake to the local register
// space and terminates the bus cycle with DTACK_n, or BERR_n on timeout.
//
// Local handshake: LOC_REQ is a level held from the edge entering ACCESS
// until the edge on which LOC_ACK is sampled, the timeout fires, or the bus
// master drops AS_n. LOC_ACK is a one-cycle pulse and is only honoured while
// a request is outstanding. An abort is signalled by a one-cycle LOC_ABORT.
module zorro_slave_target
    import zorro_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              AS_n,
    input  logic [3:0]        DS_n,
    input  logic              READ,
    input  logic [31:0]       ADDR,
    input  logic [2:0]        FC,
    input  logic              CONFIGURED,
    input  logic [7:0]        BASE,
    output logic              SLAVE_n,
    output logic              DTACK_n,
    output logic              BERR_n,
    output logic              DOE,
    output logic              LOC_REQ,
    output logic              LOC_WRITE,
    output logic [ADDR_W-1:0] LOC_ADDR,
    output logic [3:0]        LOC_BE,
    input  logic              LOC_ACK,
    output logic              LOC_ABORT,
    output zorro_state_e      DBG_STATE
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    logic              asn_s;
    logic              asn_q;
    logic [3:0]        dsn_s;
    logic              as_fall;
    logic              addr_hit;
    zorro_state_e      state;
    logic [TMR_W-1:0]  timer;
    logic              read_q;
    logic [ADDR_W-1:0] addr_q;

    // Address bits outside the base compare and longword index are not decoded.
    logic unused_addr;
    assign unused_addr = ^{ADDR[23:ADDR_W+2], ADDR[1:0]};

    zorro_sync2 #(.WIDTH(1)) u_sync_as (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .RST_VAL (1'b1),
        .D       (AS_n),
        .Q       (asn_s)
    );

    zorro_sync2 #(.WIDTH(4)) u_sync_ds (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .RST_VAL (DSN_IDLE),
        .D       (DS_n),
        .Q       (dsn_s)
    );

    assign as_fall   = ~asn_s & asn_q;
    assign addr_hit  = CONFIGURED && (ADDR[31:24] == BASE) && (FC != FC_CPU_SPACE);
    assign DBG_STATE = state;

    // Previous synchronized AS_n, used to detect the start of a new bus cycle.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) asn_q <= 1'b1;
        else          asn_q <= asn_s;
    end

    // Bus-cycle FSM with registered bus and local-side outputs.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= ST_IDLE;
            SLAVE_n   <= 1'b1;
            DTACK_n   <= 1'b1;
            BERR_n    <= 1'b1;
            DOE       <= 1'b0;
            LOC_REQ   <= 1'b0;
            LOC_WRITE <= 1'b0;
            LOC_ADDR  <= '0;
            LOC_BE    <= '0;
            LOC_ABORT <= 1'b0;
            timer     <= '0;
            read_q    <= 1'b0;
            addr_q    <= '0;
        end else begin
            LOC_ABORT <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (as_fall) begin
                        if (addr_hit) begin
                            state   <= ST_MATCH;
                            SLAVE_n <= 1'b0;
                            read_q  <= READ;
                            addr_q  <= ADDR[ADDR_W+1:2];
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                end
                ST_IGNORE: begin
                    if (asn_s) state <= ST_IDLE;
                end
                ST_MATCH: begin
                    // Master gave up before strobing data: no local access.
                    if (asn_s) begin
                        state   <= ST_IDLE;
                        SLAVE_n <= 1'b1;
                    end else if (dsn_s != DSN_IDLE) begin
                        state     <= ST_ACCESS;
                        LOC_REQ   <= 1'b1;
                        LOC_WRITE <= ~read_q;
                        LOC_ADDR  <= addr_q;
                        LOC_BE    <= ~dsn_s;
                        DOE       <= read_q;
                        timer     <= '0;
                    end
                end
                ST_ACCESS: begin
                    // Bus abort outranks a same-cycle ack; ack outranks timeout.
                    if (asn_s) begin
                        state     <= ST_IDLE;
                        LOC_REQ   <= 1'b0;
                        LOC_ABORT <= 1'b1;
                        SLAVE_n   <= 1'b1;
                        DOE       <= 1'b0;
                    end else if (LOC_ACK) begin
                        state   <= ST_RESPOND;
                        LOC_REQ <= 1'b0;
                        DTACK_n <= 1'b0;
                    end else if (timer == TMR_LAST) begin
                        state   <= ST_RESPOND;
                        LOC_REQ <= 1'b0;
                        BERR_n  <= 1'b0;
                    end else if (timer != TMR_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RESPOND: begin
                    if (asn_s) begin
                        state   <= ST_IDLE;
                        DTACK_n <= 1'b1;
                        BERR_n  <= 1'b1;
                        SLAVE_n <= 1'b1;
                        DOE     <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    SLAVE_n <= 1'b1;
                    DTACK_n <= 1'b1;
                    BERR_n  <= 1'b1;
                    DOE     <= 1'b0;
                    LOC_REQ <= 1'b0;
                end
            endcase
        end
    end

endmodule
